game_timer_counter: RTL and testbench

//  Produces the 0..99 s round countdown consumed by the on-screen two-digit counter renderer.

---
 rtl/game_timer_counter.sv | 161 ++++++++++++++++
 tb/tb_game_timer_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_counter.sv
// game_timer_counter: 0..99 s round countdown with 1 s prescaler and frame-synchronous display.
// Optional low-time warn blink when TIMER_WARN_BLINK_EN is defined; warn is tied low otherwise.
module game_timer_counter #(
  parameter int CLK_HZ        = 25_000_000,
  parameter int START_SECONDS = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [6:0] load_value,
  input  logic       frame_start,
  output logic [6:0] game_duration,
  output logic       running,
  output logic       time_up,
  output logic       sec_tick,
  output logic       expired,
  output logic       warn
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);
  localparam logic [6:0] START_CNT = 7'(START_SECONDS);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED,
    EXPIRED
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_d, exp_d;
  logic [6:0]    load_clip;

  assign load_clip = (load_value > 7'd99) ? 7'd99 : load_value;

  // Next state, count and prescaler; load > start > pause.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    exp_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          count_d = load_clip;
          presc_d = '0;
        end else if (start) begin
          presc_d = '0;
          state_d = (count_q != 7'd0) ? RUNNING : EXPIRED;
        end
      end
      RUNNING: begin
        if (pause) begin
          state_d = PAUSED;
        end else if (presc_q == PS_LAST) begin
          presc_d = '0;
          if (count_q != 7'd0) begin
            tick_d  = 1'b1;
            count_d = count_q - 7'd1;
            if (count_q == 7'd1) begin
              exp_d   = 1'b1;
              state_d = EXPIRED;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSED: begin
        if (load) begin
          count_d = load_clip;
          presc_d = '0;
          state_d = IDLE;
        end else if (start) begin
          state_d = RUNNING;
        end
      end
      EXPIRED: begin
        if (load) begin
          count_d = load_clip;
          presc_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, count, prescaler and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= START_CNT;
      presc_q  <= '0;
      running  <= 1'b0;
      time_up  <= 1'b0;
      sec_tick <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      running  <= (state_d == RUNNING);
      time_up  <= (state_d == EXPIRED);
      sec_tick <= tick_d;
      expired  <= exp_d;
    end
  end

  // Publish the count only at frame start so the renderer never sees a torn value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_duration <= START_CNT;
    end else if (frame_start) begin
      game_duration <= count_q;
    end
  end

`ifdef TIMER_WARN_BLINK_EN
  localparam logic [PW-1:0] PS_HALF = PW'(CLK_HZ / 2 - 1);

  logic warn_d;
  logic low_time;

  assign low_time = (count_q != 7'd0) && (count_q <= 7'd10);

  // Blink at each half second while low on time; freeze while paused.
  always_comb begin
    warn_d = 1'b0;
    unique case (state_q)
      RUNNING: begin
        if (low_time) begin
          if (!pause && (presc_q == PS_HALF || presc_q == PS_LAST))
            warn_d = ~warn;
          else
            warn_d = warn;
        end
      end
      PAUSED: begin
        if (low_time) warn_d = warn;
      end
      default: warn_d = 1'b0;
    endcase
  end

  // Warn register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) warn <= 1'b0;
    else     warn <= warn_d;
  end
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_counter.sv
// tb_game_timer_counter: directed checks of the round countdown timer.
// Runs with CLK_HZ=4, START_SECONDS=99.
module tb_game_timer_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause, load, frame_start;
  logic [6:0] load_value;
  logic [6:0] game_duration;
  logic       running, time_up, sec_tick, expired, warn;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  logic seen;

  always #5 clk = ~clk;

  game_timer_counter #(
    .CLK_HZ(4),
    .START_SECONDS(99)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pause(pause),
    .load(load),
    .load_value(load_value),
    .frame_start(frame_start),
    .game_duration(game_duration),
    .running(running),
    .time_up(time_up),
    .sec_tick(sec_tick),
    .expired(expired),
    .warn(warn)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p,
                       input logic l, input logic f);
    start = s; pause = p; load = l; frame_start = f;
    step();
    start = 0; pause = 0; load = 0; frame_start = 0;
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!sec_tick && cnt < 50);
  endtask

  initial begin
    rst = 1; start = 0; pause = 0; load = 0;
    frame_start = 0; load_value = '0;
    step(); step();
    rst = 0;
    step();

    check("rst_gd", game_duration, 99);
    check("rst_running", running, 0);
    check("rst_time_up", time_up, 0);
    check("rst_tick", sec_tick, 0);
    check("rst_expired", expired, 0);
    check("rst_warn", warn, 0);
    pulse(1, 0, 0, 0);
    check("t1_running", running, 1);
    pulse(0, 1, 0, 0);
    check("t1_paused", running, 0);

    load_value = 7'd3;
    pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    check("t2_load_gd", game_duration, 3);
    pulse(1, 0, 0, 0);
    wait_tick(n);
    check("t2_tick1_gap", n, 4);
    check("t2_tick1_exp", expired, 0);
    wait_tick(n);
    check("t2_tick2_gap", n, 4);
    wait_tick(n);
    check("t2_tick3_gap", n, 4);
    check("t2_expired", expired, 1);
    check("t2_time_up", time_up, 1);
    check("t2_run_off", running, 0);
    step();
    check("t2_exp_pulse", expired, 0);
    pulse(0, 0, 0, 1);
    check("t2_gd_zero", game_duration, 0);
    pulse(1, 0, 0, 0);
    check("t2_start_ign", time_up, 1);

    load_value = 7'd6;
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    wait_tick(n);
    check("t3_first_tick", n, 4);
    step(); step();
    pulse(0, 1, 0, 0);
    check("t3_paused", running, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sec_tick) seen = 1;
    end
    check("t3_no_tick", seen, 0);
    pulse(1, 0, 0, 0);
    wait_tick(n);
    check("t3_resume_gap", n, 2);
    pulse(0, 0, 0, 1);
    check("t3_count4", game_duration, 4);

    wait_tick(n);
    check("t4_gap", n, 3);
    check("t4_hold", game_duration, 4);
    step(); step(); step();
    frame_start = 1;
    step();
    frame_start = 0;
    check("t4_tick_frame", sec_tick, 1);
    check("t4_old_value", game_duration, 3);
    pulse(0, 0, 0, 1);
    check("t4_new_value", game_duration, 2);
    pulse(0, 1, 0, 0);

    load_value = 7'd120;
    pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    check("t5_clip99", game_duration, 99);
    pulse(1, 0, 0, 0);
    load_value = 7'd5;
    pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    check("t5_load_ign", game_duration, 99);
    check("t5_still_run", running, 1);
    pulse(0, 1, 0, 0);
    load_value = 7'd20;
    pulse(1, 0, 1, 0);
    check("t5_ld_st_idle", running, 0);
    repeat (5) step();
    pulse(0, 0, 0, 1);
    check("t5_ld_st_gd", game_duration, 20);
    check("t5_idle_stay", running, 0);

    load_value = 7'd0;
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    check("zero_time_up", time_up, 1);
    check("zero_no_exp", expired, 0);

    load_value = 7'd50;
    pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    step(); step();
    rst = 1;
    #1;
    check("arst_running", running, 0);
    check("arst_gd", game_duration, 99);
    rst = 0;
    step();
    check("arst_expired", expired, 0);
    check("arst_idle", running, 0);

`ifdef TIMER_WARN_BLINK_EN
    begin
      int w [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
      load_value = 7'd10;
      pulse(0, 0, 1, 0);
      pulse(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
        step();
        check($sformatf("t6_warn%0d", i), warn, w[i]);
      end
      pulse(0, 1, 0, 0);
      load_value = 7'd11;
      pulse(0, 0, 1, 0);
      pulse(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
        step();
        check($sformatf("t6_warn11_%0d", i), warn, 0);
      end
    end
`else
    load_value = 7'd10;
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    step(); step();
    check("t6_warn_off", warn, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
